// File: rtl/ets_pkg.sv
// rtl/ets_pkg.sv - shared types and constants for the ETS stream checker
package ets_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   localparam int ERR_W     = 3;
   localparam int ERR_SHORT = 0;
   localparam int ERR_LONG  = 1;
   localparam int ERR_KEEP  = 2;

endpackage

// File: rtl/ets_result_reg.sv
// rtl/ets_result_reg.sv - one-deep valid/ready holding register for frame results
module ets_result_reg #(
   parameter int W = 67
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         ready,
   input  logic [W-1:0] din,
   output logic         valid,
   output logic [W-1:0] dout
);

   // A load always wins over a same-cycle accept so the fresh record is presented
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         dout  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         dout  <= din;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ets_stream_checker.sv
// rtl/ets_stream_checker.sv - ETS stream sink that sizes, sums and checks each frame
module ets_stream_checker
   import ets_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16,
   parameter int SUM_W  = 48
) (
   input  logic                S_AXIS_aclk,
   input  logic                S_AXIS_aresetn,
   input  logic                enable,
   input  logic [CNT_W-1:0]    expected_len,
   input  logic                S_AXIS_tvalid,
   output logic                S_AXIS_tready,
   input  logic [DATA_W-1:0]   S_AXIS_tdata,
   input  logic                S_AXIS_tlast,
   input  logic [DATA_W/8-1:0] S_AXIS_tkeep,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [CNT_W-1:0]    res_len,
   output logic [SUM_W-1:0]    res_sum,
   output logic [ERR_W-1:0]    res_err,
   output logic [31:0]         frame_count,
   output logic [15:0]         err_count,
   output logic                busy
);

   localparam int RES_W = CNT_W + SUM_W + ERR_W;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt, exp_len_q, cnt_fin, len_ref;
   logic [SUM_W-1:0]   acc, acc_fin;
   logic               kerr, kerr_fin;
   logic [ERR_W-1:0]   err_fin;
   logic               beat, stall, first, keep_bad, last_beat;
   logic [RES_W-1:0]   res_bus;

   assign stall     = res_valid & ~res_ready;
   assign beat      = S_AXIS_tvalid & S_AXIS_tready;
   assign first     = (state == IDLE);
   assign keep_bad  = (S_AXIS_tkeep != '1);
   assign last_beat = beat & S_AXIS_tlast;

   // Frame totals as they stand after the current beat; the last beat's values become the result
   always_comb begin
      cnt_fin  = first ? CNT_W'(1) : ((cnt == '1) ? cnt : cnt + 1'b1);
      acc_fin  = first ? SUM_W'(S_AXIS_tdata) : acc + SUM_W'(S_AXIS_tdata);
      kerr_fin = keep_bad | (~first & kerr);
      len_ref  = first ? expected_len : exp_len_q;
      err_fin  = '0;
      err_fin[ERR_KEEP] = kerr_fin;
      if (len_ref != '0) begin
         err_fin[ERR_SHORT] = (cnt_fin < len_ref);
         err_fin[ERR_LONG]  = (cnt_fin > len_ref);
      end
   end

   // FSM state register
   always_ff @(posedge S_AXIS_aclk or negedge S_AXIS_aresetn) begin
      if (!S_AXIS_aresetn) state <= IDLE;
      else                 state <= state_nx;
   end

   // FSM next state: any beat opens a frame, a tlast beat closes it
   always_comb begin
      state_nx = state;
      if (beat) state_nx = S_AXIS_tlast ? IDLE : RECV;
   end

   // FSM outputs: enable only gates the start of a frame, a held result gates everything
   always_comb begin
      S_AXIS_tready = S_AXIS_aresetn & ~stall & ((state == RECV) | enable);
      busy          = (state == RECV);
   end

   // Per-frame accumulators; the expected length is frozen on the first beat
   always_ff @(posedge S_AXIS_aclk or negedge S_AXIS_aresetn) begin
      if (!S_AXIS_aresetn) begin
         cnt       <= '0;
         acc       <= '0;
         kerr      <= 1'b0;
         exp_len_q <= '0;
      end else if (beat) begin
         cnt  <= cnt_fin;
         acc  <= acc_fin;
         kerr <= kerr_fin;
         if (first) exp_len_q <= expected_len;
      end
   end

   // Running counters, bumped on the edge that captures the result
   always_ff @(posedge S_AXIS_aclk or negedge S_AXIS_aresetn) begin
      if (!S_AXIS_aresetn) begin
         frame_count <= '0;
         err_count   <= '0;
      end else if (last_beat) begin
         frame_count <= frame_count + 32'd1;
         if ((err_fin != '0) && (err_count != '1)) err_count <= err_count + 16'd1;
      end
   end

   ets_result_reg #(.W(RES_W)) u_result (
      .clk   (S_AXIS_aclk),
      .rst_n (S_AXIS_aresetn),
      .load  (last_beat),
      .ready (res_ready),
      .din   ({cnt_fin, acc_fin, err_fin}),
      .valid (res_valid),
      .dout  (res_bus)
   );

   assign {res_len, res_sum, res_err} = res_bus;

endmodule

// File: tb/tb_ets_stream_checker.sv
// tb/tb_ets_stream_checker.sv - randomized self-checking bench for ets_stream_checker
module tb_ets_stream_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b1;
   logic [15:0] expected_len = '0;
   logic        tvalid = 1'b0;
   logic        tready;
   logic [31:0] tdata = '0;
   logic        tlast = 1'b0;
   logic [3:0]  tkeep = 4'hF;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] res_len;
   logic [47:0] res_sum;
   logic [2:0]  res_err;
   logic [31:0] frame_count;
   logic [15:0] err_count;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic rr_rand = 1'b0, rr_force = 1'b0, en_rand = 1'b0, en_force = 1'b1;

   typedef struct {
      logic [15:0] len;
      logic [47:0] sum;
      logic [2:0]  err;
   } rec_t;

   rec_t        rq[$];
   bit          in_frame = 0;
   int          cur_len;
   longint      cur_sum;
   bit          cur_keep;
   int          cur_exp;
   int          m_frames = 0;
   int          m_errs = 0;

   ets_stream_checker dut (
      .S_AXIS_aclk    (clk),
      .S_AXIS_aresetn (rst_n),
      .enable         (enable),
      .expected_len   (expected_len),
      .S_AXIS_tvalid  (tvalid),
      .S_AXIS_tready  (tready),
      .S_AXIS_tdata   (tdata),
      .S_AXIS_tlast   (tlast),
      .S_AXIS_tkeep   (tkeep),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_len        (res_len),
      .res_sum        (res_sum),
      .res_err        (res_err),
      .frame_count    (frame_count),
      .err_count      (err_count),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Control inputs change between edges so the model and DUT see them stable
   always @(posedge clk) begin
      #2;
      enable    = en_rand ? (($urandom % 4) != 0) : en_force;
      res_ready = rr_rand ? (($urandom % 3) != 0) : rr_force;
   end

   // Reference model: compare the DUT against the model, then fold in the upcoming edge
   always @(negedge clk) begin
      bit ev, et;
      rec_t r;
      int lsat;
      if (!rst_n) begin
         chk("rst_res_valid", res_valid, 0);
         chk("rst_tready", tready, 0);
         chk("rst_busy", busy, 0);
         chk("rst_frame_count", frame_count, 0);
         chk("rst_err_count", err_count, 0);
         chk("rst_res_len", res_len, 0);
         chk("rst_res_sum", res_sum, 0);
         chk("rst_res_err", res_err, 0);
         rq.delete();
         in_frame = 0;
         m_frames = 0;
         m_errs   = 0;
      end else begin
         ev = (rq.size() != 0);
         chk("res_valid", res_valid, ev);
         if (ev) begin
            chk("res_len", res_len, rq[0].len);
            chk("res_sum", res_sum, rq[0].sum);
            chk("res_err", res_err, rq[0].err);
         end
         chk("frame_count", frame_count, m_frames);
         chk("err_count", err_count, m_errs);
         chk("busy", busy, in_frame);
         et = !(ev && !res_ready) && (in_frame || enable);
         chk("tready", tready, et);
         if (ev && res_ready) void'(rq.pop_front());
         if (tvalid && et) begin
            if (!in_frame) begin
               in_frame = 1;
               cur_len  = 0;
               cur_sum  = 0;
               cur_keep = 0;
               cur_exp  = expected_len;
            end
            cur_len++;
            cur_sum += longint'(tdata);
            if (tkeep != 4'hF) cur_keep = 1;
            if (tlast) begin
               lsat  = (cur_len > 65535) ? 65535 : cur_len;
               r.len = lsat[15:0];
               r.sum = cur_sum[47:0];
               r.err = {cur_keep, (cur_exp != 0) && (lsat > cur_exp), (cur_exp != 0) && (lsat < cur_exp)};
               rq.push_back(r);
               m_frames++;
               if (r.err != 0 && m_errs < 65535) m_errs++;
               in_frame = 0;
            end
         end
      end
   end

   task automatic put(input logic [31:0] d, input logic l, input logic [3:0] k);
      int n = 0;
      logic ok = 1'b0;
      tdata  = d;
      tlast  = l;
      tkeep  = k;
      tvalid = 1'b1;
      while (!ok && n < 2000) begin
         @(negedge clk);
         ok = tready;
         @(posedge clk);
         #1;
         n++;
      end
      tvalid = 1'b0;
      if (!ok) chk("put_timeout", 0, 1);
   endtask

   task automatic pulse_ready();
      @(posedge clk); #1 rr_force = 1'b1;
      @(posedge clk); #1 rr_force = 1'b0;
   endtask

   task automatic wait_res(input string name, input logic [15:0] l, input logic [47:0] s, input logic [2:0] e);
      int n = 0;
      @(negedge clk);
      while (!res_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_valid"}, res_valid, 1);
      chk({name, "_len"}, res_len, l);
      chk({name, "_sum"}, res_sum, s);
      chk({name, "_err"}, res_err, e);
      pulse_ready();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("lit_reset_frame_count", frame_count, 0);
      chk("lit_reset_res_valid", res_valid, 0);
      #5 rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic 4-word frame
      expected_len = 16'd4;
      for (int i = 1; i <= 4; i++) put(32'(i), i == 4, 4'hF);
      wait_res("t1", 16'd4, 48'd10, 3'b000);
      chk("t1_frame_count", frame_count, 1);

      // Short then long frame
      for (int i = 1; i <= 3; i++) put(32'(i), i == 3, 4'hF);
      wait_res("t2a", 16'd3, 48'd6, 3'b001);
      for (int i = 1; i <= 6; i++) put(32'(i), i == 6, 4'hF);
      wait_res("t2b", 16'd6, 48'd21, 3'b010);
      chk("t2_err_count", err_count, 2);
      chk("t2_frame_count", frame_count, 3);

      // Pending result stalls the stream without losing the next frame
      expected_len = 16'd0;
      for (int i = 1; i <= 3; i++) put(32'(i), i == 3, 4'hF);
      @(negedge clk);
      chk("t3_valid_rise", res_valid, 1);
      chk("t3_tready_low", tready, 0);
      fork
         for (int i = 1; i <= 4; i++) put(32'(10 * i), i == 4, 4'hF);
         begin
            repeat (5) @(negedge clk);
            chk("t3_still_stalled", tready, 0);
            pulse_ready();
         end
      join
      wait_res("t3b", 16'd4, 48'd100, 3'b000);

      // Enable dropped mid-frame
      expected_len = 16'd5;
      put(32'd7, 1'b0, 4'hF);
      en_force = 1'b0;
      for (int i = 2; i <= 5; i++) put(32'd7, i == 5, 4'hF);
      wait_res("t4", 16'd5, 48'd35, 3'b000);
      tvalid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("t4_tready_idle", tready, 0);
      end
      @(posedge clk); #1;
      tvalid   = 1'b0;
      en_force = 1'b1;

      // tkeep error and single-word frame
      expected_len = 16'd0;
      put(32'd5, 1'b0, 4'hF);
      put(32'd6, 1'b0, 4'h7);
      put(32'd7, 1'b1, 4'hF);
      wait_res("t5a", 16'd3, 48'd18, 3'b100);
      put(32'hFFFF_FFFF, 1'b1, 4'hF);
      wait_res("t5b", 16'd1, 48'hFFFF_FFFF, 3'b000);
      chk("t5_err_count", err_count, 3);

      // Randomized traffic with random result back-pressure and enable
      rr_rand = 1'b1;
      en_rand = 1'b1;
      for (int f = 0; f < 40; f++) begin
         int len = $urandom_range(1, 8);
         expected_len = 16'($urandom_range(0, 6));
         for (int w = 0; w < len; w++) begin
            if (($urandom % 5) == 0) expected_len = 16'($urandom_range(0, 6));
            put($urandom, w == len - 1, (($urandom % 10) == 0) ? 4'hB : 4'hF);
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
         end
      end
      rr_rand  = 1'b0;
      en_rand  = 1'b0;
      rr_force = 1'b1;
      for (int n = 0; n < 50 && rq.size() != 0; n++) @(negedge clk);
      chk("drain_empty", rq.size(), 0);
      @(posedge clk); #1 rr_force = 1'b0;

      // Reset in the middle of a frame
      put(32'd1, 1'b0, 4'hF);
      put(32'd2, 1'b0, 4'hF);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_frame_count", frame_count, 0);
      chk("t6_busy", busy, 0);
      chk("t6_tready", tready, 0);
      @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;
      expected_len = 16'd2;
      put(32'd10, 1'b0, 4'hF);
      put(32'd20, 1'b1, 4'hF);
      wait_res("t6", 16'd2, 48'd30, 3'b000);
      chk("t6_frame_count_after", frame_count, 1);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
